// File: rtl/rgb_led_pkg.sv
// -----------------------------------------------------------------------------
// rgb_led_pkg
//
// Shared definitions for the RGB LED sequencer:
//   - color_e        : 2-bit colour state encoding (IDLE=0, RED=1, GREEN=2,
//                      BLUE=3), driven straight onto the color_state output.
//   - counter_width  : bits needed for a counter that holds 0..cycles-1.
//   - next_color     : colour advance order IDLE->RED->GREEN->BLUE->RED.
// -----------------------------------------------------------------------------
package rgb_led_pkg;

    typedef enum logic [1:0] {
        COLOR_IDLE  = 2'd0,
        COLOR_RED   = 2'd1,
        COLOR_GREEN = 2'd2,
        COLOR_BLUE  = 2'd3
    } color_e;

    // Width of a counter that must represent 0..cycles-1; never narrower
    // than one bit, so a cycle count of 1 still yields a legal vector.
    function automatic int counter_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

    // IDLE is only a starting point: once the sequence runs it loops
    // through the three colours and never returns to IDLE on its own.
    function automatic color_e next_color(input color_e current);
        case (current)
            COLOR_IDLE:  return COLOR_RED;
            COLOR_RED:   return COLOR_GREEN;
            COLOR_GREEN: return COLOR_BLUE;
            default:     return COLOR_RED;
        endcase
    endfunction

endpackage

// File: rtl/rgb_led_sequencer_debouncer.sv
// -----------------------------------------------------------------------------
// button_debouncer
//
// Conditions one active-low, asynchronous push button.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive cycles the synchronised level must differ
//                     from the debounced level before the debounced level
//                     follows it.
// Ports:
//   clock    in  system clock
//   reset    in  synchronous, active-high reset
//   button_n in  raw button pin, active-low, asynchronous to clock
//   level    out debounced button level, active-high (1 = pressed)
//   press    out one-cycle pulse in the cycle the debounced level rises
// -----------------------------------------------------------------------------
module button_debouncer
    import rgb_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic button_n,
    output logic level,
    output logic press
);

    localparam int                CNT_W    = counter_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic [CNT_W-1:0] r_count;
    logic             w_differs;
    logic             w_settle;

    // The pin is inverted on its way into the first flop, so both
    // synchroniser stages hold the active-high level and their reset value
    // of 0 already reads as "released"; a button held through reset is then
    // seen as a fresh edge once reset lifts.
    assign w_differs = (r_sync2 != r_level);

    // Last cycle of an unbroken run of disagreement: the debounced level
    // flips on this edge.
    assign w_settle  = w_differs && (r_count == CNT_LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others; with blocking assignments
    // the two synchroniser stages would collapse into one.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= ~button_n;
            r_sync2 <= r_sync1;
            if (!w_differs) begin
                // Any return to agreement restarts the stability interval.
                r_count <= '0;
            end else if (w_settle) begin
                r_count <= '0;
                r_level <= r_sync2;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign level = r_level;

    // The press pulse coincides with the settling cycle of a rising level,
    // so downstream logic acts on the same edge the level goes high.
    // Releases never generate an event.
    assign press = w_settle && r_sync2;

endmodule

// File: rtl/rgb_led_sequencer.sv
// -----------------------------------------------------------------------------
// rgb_led_sequencer
//
// Steps the board RGB LEDs through IDLE/RED/GREEN/BLUE from two push buttons,
// either manually (button0 presses) or automatically on a dwell timer that is
// armed by holding button0. The lit colour is dimmed by a fixed-duty PWM.
//
// Parameters:
//   DEBOUNCE_CYCLES : button stability interval in cycles
//   HOLD_CYCLES     : debounced button0 hold time that enters auto mode
//   DWELL_CYCLES    : cycles spent on each colour in auto mode
//   PWM_BITS        : width of the free-running PWM counter
//   DUTY            : on-cycles per PWM period, 0..2**PWM_BITS
// Ports:
//   clock          in  system clock
//   reset          in  synchronous, active-high reset
//   push_button0_n in  advance button, active-low, asynchronous
//   push_button1_n in  return-to-idle button, active-low, asynchronous
//   led_red_n      out red LED drive, active-low, registered
//   led_green_n    out green LED drive, active-low, registered
//   led_blue_n     out blue LED drive, active-low, registered
//   color_state    out current colour (IDLE=0, RED=1, GREEN=2, BLUE=3)
//   auto_mode      out 1 while auto-advance is active
// -----------------------------------------------------------------------------
module rgb_led_sequencer
    import rgb_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int HOLD_CYCLES     = 25000000,
    parameter int DWELL_CYCLES    = 12500000,
    parameter int PWM_BITS        = 8,
    parameter int DUTY            = 128
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push_button0_n,
    input  logic       push_button1_n,
    output logic       led_red_n,
    output logic       led_green_n,
    output logic       led_blue_n,
    output logic [1:0] color_state,
    output logic       auto_mode
);

    // The hold counter must reach HOLD_CYCLES itself (it saturates there),
    // so it needs room for HOLD_CYCLES+1 values.
    localparam int                   HOLD_W     = counter_width(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0]    HOLD_FULL  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]    HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
    localparam int                   DWELL_W    = counter_width(DWELL_CYCLES);
    localparam logic [DWELL_W-1:0]   DWELL_LAST = DWELL_W'(DWELL_CYCLES - 1);
    // One extra bit so DUTY = 2**PWM_BITS compares above every count value.
    localparam logic [PWM_BITS:0]    DUTY_LIMIT = (PWM_BITS + 1)'(DUTY);

    // ------------------------------------------------------------------
    // Button conditioning
    // ------------------------------------------------------------------
    logic w_b0_level;
    logic w_b0_press;
    logic w_b1_press;
    // button1 acts only through its press event; its level has no reader.
    logic w_b1_level_unused;

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button0 (
        .clock    (clock),
        .reset    (reset),
        .button_n (push_button0_n),
        .level    (w_b0_level),
        .press    (w_b0_press)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_button1 (
        .clock    (clock),
        .reset    (reset),
        .button_n (push_button1_n),
        .level    (w_b1_level_unused),
        .press    (w_b1_press)
    );

    // ------------------------------------------------------------------
    // Hold counter: measures how long button0 stays pressed in manual mode.
    // It stops at HOLD_CYCLES and only clears on release, so one long press
    // enters auto mode once and cannot re-trigger it.
    // ------------------------------------------------------------------
    logic [HOLD_W-1:0] r_hold;
    logic              w_hold_reached;
    logic              r_auto;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_hold <= '0;
        end else if (!w_b0_level) begin
            r_hold <= '0;
        end else if (!r_auto && (r_hold != HOLD_FULL)) begin
            r_hold <= r_hold + 1'b1;
        end
    end

    // True in the cycle whose edge brings the counter to HOLD_CYCLES.
    assign w_hold_reached = w_b0_level && !r_auto && (r_hold == HOLD_LAST);

    // ------------------------------------------------------------------
    // Colour FSM with auto-mode flag and dwell counter.
    // Event priority: button1 press > button0 press > hold > dwell expiry.
    // ------------------------------------------------------------------
    color_e             r_color;
    color_e             w_color_next;
    logic               w_auto_next;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] w_dwell_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_color <= COLOR_IDLE;
            r_auto  <= 1'b0;
            r_dwell <= '0;
        end else begin
            r_color <= w_color_next;
            r_auto  <= w_auto_next;
            r_dwell <= w_dwell_next;
        end
    end

    // NOTE: every output of this block is given its hold value first, so
    // any path that does not reassign it still drives it and no latch forms.
    always_comb begin
        w_color_next = r_color;
        w_auto_next  = r_auto;
        w_dwell_next = r_dwell;

        if (w_b1_press) begin
            w_color_next = COLOR_IDLE;
            w_auto_next  = 1'b0;
            w_dwell_next = '0;
        end else if (w_b0_press) begin
            // In auto mode a press only leaves auto mode; the colour stays.
            if (!r_auto) begin
                w_color_next = next_color(r_color);
            end
            w_auto_next  = 1'b0;
            w_dwell_next = '0;
        end else if (w_hold_reached) begin
            w_auto_next  = 1'b1;
            w_dwell_next = '0;
        end else if (r_auto) begin
            // Wrapping at DWELL_CYCLES-1 makes each colour last exactly
            // DWELL_CYCLES cycles.
            if (r_dwell == DWELL_LAST) begin
                w_dwell_next = '0;
                w_color_next = next_color(r_color);
            end else begin
                w_dwell_next = r_dwell + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // PWM and registered LED drives
    // ------------------------------------------------------------------
    logic [PWM_BITS-1:0] r_pwm;
    logic                w_pwm_on;
    logic                r_led_red_n;
    logic                r_led_green_n;
    logic                r_led_blue_n;

    assign w_pwm_on = ({1'b0, r_pwm} < DUTY_LIMIT);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pwm         <= '0;
            r_led_red_n   <= 1'b1;
            r_led_green_n <= 1'b1;
            r_led_blue_n  <= 1'b1;
        end else begin
            r_pwm         <= r_pwm + 1'b1;
            // Driven from the registered colour, so the LEDs trail a colour
            // change by one cycle and are glitch-free at the pins.
            r_led_red_n   <= ~((r_color == COLOR_RED)   && w_pwm_on);
            r_led_green_n <= ~((r_color == COLOR_GREEN) && w_pwm_on);
            r_led_blue_n  <= ~((r_color == COLOR_BLUE)  && w_pwm_on);
        end
    end

    assign led_red_n   = r_led_red_n;
    assign led_green_n = r_led_green_n;
    assign led_blue_n  = r_led_blue_n;
    assign color_state = r_color;
    assign auto_mode   = r_auto;

endmodule
